csr_file: RTL and testbench

- Parametrised control/status register file for the RISC-V core, successor to the single-register tohost CSR.
- Holds tohost, a bank of scratch registers and 64-bit cycle/instret counters.
- Supports CSRRW/CSRRS/CSRRC semantics with a one-cycle pipelined commit and read bypass.
- Sits beside the execute stage: request presented in execute, write committed at the next clock edge.

---
 rtl/csr_file.sv | 148 ++++++++++++++
 tb/tb_csr_file.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// Control/status register file for the RISC-V core: tohost, scratch bank and
// 64-bit cycle/instret counters, with CSRRW/CSRRS/CSRRC ops and a one-deep commit pipeline.
module csr_file #(
  parameter int          XLEN         = 32,
  parameter int          NUM_SCRATCH  = 4,
  parameter logic [11:0] SCRATCH_BASE = 12'h340,
  parameter logic [11:0] TOHOST_ADDR  = 12'h51E,
  parameter int          CNT_WIDTH    = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            instr_retire,
  output logic [XLEN-1:0] csr_rdata,
  output logic [XLEN-1:0] tohost,
  output logic            tohost_valid,
  output logic            illegal
);

  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;

  csr_op_e op;
  assign op = csr_op_e'(csr_op);

  // Architectural state
  logic [XLEN-1:0]      tohost_q;
  logic [XLEN-1:0]      scratch_q [NUM_SCRATCH];
  logic [CNT_WIDTH-1:0] cycle_q;
  logic [CNT_WIDTH-1:0] instret_q;

  // Pending commit stage and registered illegal pulse
  logic            p_we_q,   p_we_d;
  logic [11:0]     p_addr_q;
  logic [XLEN-1:0] p_data_q, p_data_d;
  logic            illegal_q, illegal_d;

  // Counters padded to two words so the high half is zero-extended for free
  logic [2*XLEN-1:0] cycle_ext;
  logic [2*XLEN-1:0] instret_ext;
  assign cycle_ext   = (2*XLEN)'(cycle_q);
  assign instret_ext = (2*XLEN)'(instret_q);

  logic [XLEN-1:0] arch_val;
  logic [XLEN-1:0] old_val;
  logic            mapped;
  logic            read_only;
  logic            wr_req;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    arch_val  = '0;
    mapped    = 1'b0;
    read_only = 1'b0;
    if (csr_addr == TOHOST_ADDR) begin
      arch_val = tohost_q;
      mapped   = 1'b1;
    end
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (csr_addr == SCRATCH_BASE + 12'(i)) begin
        arch_val = scratch_q[i];
        mapped   = 1'b1;
      end
    end
    case (csr_addr)
      ADDR_CYCLE:    begin arch_val = cycle_ext[XLEN-1:0];        mapped = 1'b1; read_only = 1'b1; end
      ADDR_CYCLEH:   begin arch_val = cycle_ext[2*XLEN-1:XLEN];   mapped = 1'b1; read_only = 1'b1; end
      ADDR_INSTRET:  begin arch_val = instret_ext[XLEN-1:0];      mapped = 1'b1; read_only = 1'b1; end
      ADDR_INSTRETH: begin arch_val = instret_ext[2*XLEN-1:XLEN]; mapped = 1'b1; read_only = 1'b1; end
      default: ;
    endcase
  end

  // A write still sitting in the pending stage is newer than the register it targets
  assign old_val = (p_we_q && (p_addr_q == csr_addr)) ? p_data_q : arch_val;

  // Set/clear with an empty mask never modifies anything, so it is not a write
  assign wr_req = csr_en && ((op == OP_WRITE) ||
                  (((op == OP_SET) || (op == OP_CLEAR)) && (csr_wdata != '0)));

  always_comb begin
    p_data_d = old_val;
    case (op)
      OP_WRITE: p_data_d = csr_wdata;
      OP_SET:   p_data_d = old_val | csr_wdata;
      OP_CLEAR: p_data_d = old_val & ~csr_wdata;
      default:  p_data_d = old_val;
    endcase
  end

  assign p_we_d    = wr_req && mapped && !read_only;
  assign illegal_d = csr_en && (!mapped || (read_only && wr_req));

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_we_q    <= 1'b0;
      p_addr_q  <= '0;
      p_data_q  <= '0;
      illegal_q <= 1'b0;
      tohost_q  <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
      // NOTE: the scratch bank is architecturally visible, so it is reset like any other register.
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_q[i] <= '0;
      end
    end else begin
      p_we_q    <= p_we_d;
      p_addr_q  <= csr_addr;
      p_data_q  <= p_data_d;
      illegal_q <= illegal_d;
      if (p_we_q) begin
        if (p_addr_q == TOHOST_ADDR) begin
          tohost_q <= p_data_q;
        end
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (p_addr_q == SCRATCH_BASE + 12'(i)) begin
            scratch_q[i] <= p_data_q;
          end
        end
      end
      cycle_q <= cycle_q + CNT_WIDTH'(1);
      if (instr_retire) begin
        instret_q <= instret_q + CNT_WIDTH'(1);
      end
    end
  end

  // tohost shows a committed write in the cycle right after its request
  assign tohost_valid = p_we_q && (p_addr_q == TOHOST_ADDR);
  assign tohost       = tohost_valid ? p_data_q : tohost_q;
  assign csr_rdata    = csr_en ? old_val : '0;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file: default 32/64 instance plus a
// narrow 8/12 instance used to reach counter wrap-around quickly.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        instr_retire;
  logic [31:0] csr_rdata;
  logic [31:0] tohost;
  logic        tohost_valid;
  logic        illegal;

  logic        s_en;
  logic [11:0] s_addr;
  logic [7:0]  s_rdata;
  logic [7:0]  s_tohost;
  logic        s_valid;
  logic        s_illegal;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_model;

  always #5 clk = ~clk;

  csr_file dut (
    .clk          (clk),
    .rst          (rst),
    .csr_en       (csr_en),
    .csr_op       (csr_op),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .instr_retire (instr_retire),
    .csr_rdata    (csr_rdata),
    .tohost       (tohost),
    .tohost_valid (tohost_valid),
    .illegal      (illegal)
  );

  csr_file #(.XLEN(8), .CNT_WIDTH(12)) dut_small (
    .clk          (clk),
    .rst          (rst),
    .csr_en       (s_en),
    .csr_op       (2'b00),
    .csr_addr     (s_addr),
    .csr_wdata    (8'h00),
    .instr_retire (1'b0),
    .csr_rdata    (s_rdata),
    .tohost       (s_tohost),
    .tohost_valid (s_valid),
    .illegal      (s_illegal)
  );

  // Edges seen since reset released; both instances share this reset
  always @(posedge clk) begin
    if (rst) cyc_model <= 0;
    else     cyc_model <= cyc_model + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata);
    csr_en    = 1'b1;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wdata;
    #1;
  endtask

  task automatic idle();
    csr_en    = 1'b0;
    csr_op    = 2'b00;
    csr_addr  = 12'h000;
    csr_wdata = 32'h0;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] pat;
    int guard;
    pat          = 12'b1011_0110_1010;
    rst          = 1'b1;
    instr_retire = 1'b0;
    s_en         = 1'b0;
    s_addr       = 12'h000;
    idle();
    repeat (3) tick();
    check("rst_rdata",  csr_rdata,    32'h0);
    check("rst_tohost", tohost,       32'h0);
    check("rst_valid",  tohost_valid, 1'b0);
    check("rst_illegal", illegal,     1'b0);

    // Five idle cycles after reset release
    rst = 1'b0;
    repeat (5) tick();
    drive(2'b00, 12'hC00, 32'h0);
    check("cycle_after_5", csr_rdata, 32'd5);
    drive(2'b00, 12'hC80, 32'h0);
    check("cycleh_zero", csr_rdata, 32'h0);
    drive(2'b00, 12'hC02, 32'h0);
    check("instret_zero", csr_rdata, 32'h0);
    tick();

    // tohost write and one-cycle pulse
    drive(2'b01, 12'h51E, 32'h1);
    check("tohost_req_rdata", csr_rdata, 32'h0);
    tick();
    idle();
    check("tohost_val", tohost, 32'h1);
    check("tohost_pulse", tohost_valid, 1'b1);
    tick();
    check("tohost_pulse_end", tohost_valid, 1'b0);
    check("tohost_hold", tohost, 32'h1);

    // Set with empty mask is not a write; set with a real mask is
    drive(2'b10, 12'h51E, 32'h0);
    tick();
    idle();
    check("set_zero_nopulse", tohost_valid, 1'b0);
    drive(2'b10, 12'h51E, 32'h10);
    check("set_old", csr_rdata, 32'h1);
    tick();
    idle();
    check("set_tohost", tohost, 32'h11);
    check("set_pulse", tohost_valid, 1'b1);
    tick();

    // Back-to-back scratch0 write/set/clear through the bypass
    drive(2'b01, 12'h340, 32'hF0F0);
    check("scr_w_rdata", csr_rdata, 32'h0);
    tick();
    drive(2'b10, 12'h340, 32'h000F);
    check("scr_s_bypass", csr_rdata, 32'hF0F0);
    check("scr_no_tohost_pulse", tohost_valid, 1'b0);
    tick();
    drive(2'b11, 12'h340, 32'h00F0);
    check("scr_c_bypass", csr_rdata, 32'hF0FF);
    tick();
    drive(2'b00, 12'h340, 32'h0);
    check("scr_final_bypass", csr_rdata, 32'hF00F);
    tick();
    idle();
    tick();
    drive(2'b00, 12'h340, 32'h0);
    check("scr_final_reg", csr_rdata, 32'hF00F);
    drive(2'b00, 12'h343, 32'h0);
    check("scr3_untouched", csr_rdata, 32'h0);
    tick();

    // Illegal: write to counter, then unmapped read
    drive(2'b01, 12'hC00, 32'h5);
    check("ill_cnt_rdata", csr_rdata, 32'(cyc_model));
    check("ill_before", illegal, 1'b0);
    tick();
    drive(2'b00, 12'h7FF, 32'h0);
    check("ill_cnt_pulse", illegal, 1'b1);
    check("ill_unmapped_rdata", csr_rdata, 32'h0);
    tick();
    idle();
    check("ill_unmapped_pulse", illegal, 1'b1);
    tick();
    check("ill_end", illegal, 1'b0);
    drive(2'b00, 12'hC00, 32'h0);
    check("cycle_unaffected", csr_rdata, 32'(cyc_model));
    drive(2'b10, 12'hC00, 32'h0);
    tick();
    idle();
    check("cnt_set_zero_legal", illegal, 1'b0);

    // instret: 7 retires in 12 cycles
    for (int i = 0; i < 12; i++) begin
      instr_retire = pat[i];
      tick();
    end
    instr_retire = 1'b1;
    drive(2'b00, 12'hC02, 32'h0);
    check("instret_7", csr_rdata, 32'd7);
    drive(2'b00, 12'hC82, 32'h0);
    check("instreth_0", csr_rdata, 32'h0);
    tick();
    instr_retire = 1'b0;
    drive(2'b00, 12'hC02, 32'h0);
    check("instret_8", csr_rdata, 32'd8);
    tick();

    // tohost write with reset on the commit edge
    drive(2'b01, 12'h51E, 32'hAA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("rst_mid_tohost", tohost, 32'h0);
    check("rst_mid_valid", tohost_valid, 1'b0);
    tick();
    check("rst_mid_tohost2", tohost, 32'h0);
    check("rst_mid_valid2", tohost_valid, 1'b0);

    // Counter wrap on the 8-bit / 12-bit-counter instance
    guard = 0;
    while (cyc_model != 4094 && guard < 6000) begin
      tick();
      guard++;
    end
    check("wrap_reach", 32'(cyc_model), 32'd4094);
    s_en = 1'b1;
    s_addr = 12'hC00; #1;
    check("wrap_lo_fe", s_rdata, 8'hFE);
    s_addr = 12'hC80; #1;
    check("wrap_hi_f_a", s_rdata, 8'h0F);
    tick();
    s_addr = 12'hC00; #1;
    check("wrap_lo_ff", s_rdata, 8'hFF);
    s_addr = 12'hC80; #1;
    check("wrap_hi_f_b", s_rdata, 8'h0F);
    tick();
    s_addr = 12'hC00; #1;
    check("wrap_lo_00", s_rdata, 8'h00);
    s_addr = 12'hC80; #1;
    check("wrap_hi_00", s_rdata, 8'h00);
    s_en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
